// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the seg_scan_ctrl 4-digit 7-segment scanner.
// The state encoding, load_data field layout and all-off constants live here.
package seg_scan_ctrl_pkg;

    typedef enum logic {
        ST_DRIVE = 1'b0,
        ST_GAP   = 1'b1
    } scan_state_e;

    localparam int LD_BLINK_BIT = 5;
    localparam int LD_BLANK_BIT = 4;
    localparam int LD_VALUE_LSB = 0;
    localparam int LD_VALUE_W   = 4;

    localparam logic [3:0] AN_OFF  = 4'hF;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef struct packed {
        logic       blink;
        logic       blank;
        logic [3:0] value;
    } slot_t;

    localparam slot_t SLOT_RESET = '{blink: 1'b0, blank: 1'b1, value: 4'h0};

    function automatic slot_t slot_from_data(input logic [5:0] data);
        slot_t s;
        s.blink = data[LD_BLINK_BIT];
        s.blank = data[LD_BLANK_BIT];
        s.value = data[LD_VALUE_LSB +: LD_VALUE_W];
        return s;
    endfunction

    // A slot is dark when blanked, or when it blinks and the blink phase is off.
    function automatic logic slot_hidden(input slot_t s, input logic blink_off);
        return s.blank | (s.blink & blink_off);
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_hex_decode.sv
// Combinational hex-to-7-segment decoder, active-low, bit6=a .. bit0=g.
module seg_hex_decode (
    input  logic [3:0] value_i,
    output logic [6:0] seg_n_o
);

    // Hex digit to segment pattern lookup
    always_comb begin
        seg_n_o = 7'h7F;
        case (value_i)
            4'h0:    seg_n_o = 7'h01;
            4'h1:    seg_n_o = 7'h4F;
            4'h2:    seg_n_o = 7'h12;
            4'h3:    seg_n_o = 7'h06;
            4'h4:    seg_n_o = 7'h4C;
            4'h5:    seg_n_o = 7'h24;
            4'h6:    seg_n_o = 7'h20;
            4'h7:    seg_n_o = 7'h0F;
            4'h8:    seg_n_o = 7'h00;
            4'h9:    seg_n_o = 7'h04;
            4'hA:    seg_n_o = 7'h08;
            4'hB:    seg_n_o = 7'h60;
            4'hC:    seg_n_o = 7'h31;
            4'hD:    seg_n_o = 7'h42;
            4'hE:    seg_n_o = 7'h30;
            4'hF:    seg_n_o = 7'h38;
            default: seg_n_o = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit multiplexed 7-segment scan controller with frame-synchronous shadow load.
// Optional blink support is enabled by defining SEG_SCAN_BLINK_EN.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [1:0] load_idx,
    input  logic [5:0] load_data,
    output logic       frame_tick,
    output logic [3:0] an_n,
    output logic [6:0] seg_n
);

    localparam logic [15:0] PRESC_LAST = 16'(SCAN_DIV - 1);

    scan_state_e state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] presc_q, presc_d;
    slot_t [3:0] shadow_q, shadow_d;
    slot_t [3:0] active_q, active_d;
    logic        tick_q, tick_d;
    logic        ready_q, ready_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;

    slot_t       cur_s;
    logic [6:0]  dec_seg_s;
    logic        blink_off_s;
    logic        commit_s;

    // The commit cycle is the registered GAP-of-digit-3 cycle, so it never
    // fires in the first post-reset GAP.
    assign commit_s = tick_q;
    assign cur_s    = active_q[idx_q];

    seg_hex_decode u_hex_decode (
        .value_i (cur_s.value),
        .seg_n_o (dec_seg_s)
    );

    // Scan FSM next-state and prescaler
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        presc_d = presc_q;
        case (state_q)
            ST_DRIVE: begin
                if (presc_q == PRESC_LAST) begin
                    state_d = ST_GAP;
                    presc_d = 16'd0;
                end else begin
                    presc_d = presc_q + 16'd1;
                end
            end
            ST_GAP: begin
                state_d = ST_DRIVE;
                idx_d   = idx_q + 2'd1;
                presc_d = 16'd0;
            end
            default: begin
                state_d = ST_GAP;
                idx_d   = 2'd3;
                presc_d = 16'd0;
            end
        endcase
        // Registered so that tick and the ready hold-off line up with the commit cycle
        tick_d  = (state_d == ST_GAP) && (idx_d == 2'd3);
        ready_d = ~tick_d;
    end

    // Shadow write and frame-synchronous commit
    always_comb begin
        shadow_d = shadow_q;
        if (load_valid && ready_q) begin
            shadow_d[load_idx] = slot_from_data(load_data);
        end else begin
            shadow_d[load_idx] = shadow_q[load_idx];
        end
        if (commit_s) begin
            active_d = shadow_q;
        end else begin
            active_d = active_q;
        end
    end

`ifdef SEG_SCAN_BLINK_EN
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_DIV - 1);

    logic [7:0] fcnt_q, fcnt_d;
    logic       phase_q, phase_d;

    // Frame counter toggles the blink phase every BLINK_DIV frames
    always_comb begin
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (commit_s) begin
            if (fcnt_q == BLINK_LAST) begin
                fcnt_d  = 8'd0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + 8'd1;
            end
        end else begin
            fcnt_d = fcnt_q;
        end
    end

    // Blink frame counter and phase registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt_q  <= 8'd0;
            phase_q <= 1'b0;
        end else begin
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
        end
    end

    assign blink_off_s = phase_q;
`else
    assign blink_off_s = 1'b0;
`endif

    // Registered anode/segment drive derived from the current state and digit
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        if (state_q == ST_DRIVE) begin
            an_d = AN_OFF & ~(4'b0001 << idx_q);
            if (slot_hidden(cur_s, blink_off_s)) begin
                seg_d = SEG_OFF;
            end else begin
                seg_d = dec_seg_s;
            end
        end else begin
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
        end
    end

    // State, slot and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_GAP;
            idx_q    <= 2'd3;
            presc_q  <= 16'd0;
            shadow_q <= {4{SLOT_RESET}};
            active_q <= {4{SLOT_RESET}};
            tick_q   <= 1'b0;
            ready_q  <= 1'b0;
            an_q     <= AN_OFF;
            seg_q    <= SEG_OFF;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            presc_q  <= presc_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            tick_q   <= tick_d;
            ready_q  <= ready_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    assign load_ready = ready_q;
    assign frame_tick = tick_q;
    assign an_n       = an_q;
    assign seg_n      = seg_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl with SCAN_DIV=4, BLINK_DIV=2.
module tb_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [1:0] load_idx = 2'd0;
    logic [5:0] load_data = 6'd0;
    logic       frame_tick;
    logic [3:0] an_n;
    logic [6:0] seg_n;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic seen_a = 1'b0;

    seg_scan_ctrl #(.SCAN_DIV(4), .BLINK_DIV(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_idx   (load_idx),
        .load_data  (load_data),
        .frame_tick (frame_tick),
        .an_n       (an_n),
        .seg_n      (seg_n)
    );

    always #5 clk = ~clk;

    // Watch for the overwritten 0xA pattern ever reaching the display
    always @(negedge clk) begin
        if (seg_n === 7'h08) seen_a = 1'b1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    task automatic do_write(input logic [1:0] idx, input logic [5:0] data);
        load_valid = 1'b1;
        load_idx   = idx;
        load_data  = data;
        step();
        load_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_an;
        int p;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_an", 16'(an_n), 16'hF);
        chk("rst_seg", 16'(seg_n), 16'h7F);
        chk("rst_ready", 16'(load_ready), 16'h0);
        chk("rst_tick", 16'(frame_tick), 16'h0);
        rst = 1'b0;
        cyc = 0;

        step();
        chk("ready_first_edge", 16'(load_ready), 16'h1);
        chk("an_first_edge", 16'(an_n), 16'hF);

        // First frame scan pattern, no writes
        for (int c = 2; c <= 21; c++) begin
            goto(c);
            p = c - 2;
            exp_an = (p % 5 == 4) ? 4'hF : (4'hF & ~(4'b0001 << (p / 5)));
            chk("scan_an", 16'(an_n), 16'(exp_an));
            chk("scan_seg", 16'(seg_n), 16'h7F);
            if (c == 19) chk("tick_idle", 16'(frame_tick), 16'h0);
            if (c == 20) begin
                chk("tick_wrap", 16'(frame_tick), 16'h1);
                chk("ready_commit", 16'(load_ready), 16'h0);
            end
        end

        // Shadow write not visible until the next frame
        goto(22);
        do_write(2'd0, 6'h08);
        goto(24);
        chk("d0_same_frame_an", 16'(an_n), 16'hE);
        chk("d0_same_frame_seg", 16'(seg_n), 16'h7F);
        goto(40);
        chk("tick_frame2", 16'(frame_tick), 16'h1);
        goto(42);
        chk("d0_next_frame_an", 16'(an_n), 16'hE);
        chk("d0_next_frame_seg", 16'(seg_n), 16'h00);

        // Write held off during the commit cycle
        goto(60);
        load_valid = 1'b1;
        load_idx   = 2'd0;
        load_data  = 6'h05;
        chk("hold_ready", 16'(load_ready), 16'h0);
        chk("hold_tick", 16'(frame_tick), 16'h1);
        step();
        chk("hold_ready_after", 16'(load_ready), 16'h1);
        step();
        load_valid = 1'b0;
        chk("hold_old_value", 16'(seg_n), 16'h00);

        // Repeated writes to one slot and a blanked slot
        goto(66);
        do_write(2'd2, 6'h0A);
        goto(68);
        do_write(2'd2, 6'h01);
        goto(70);
        do_write(2'd1, 6'h18);
        goto(72);
        chk("d2_pending_an", 16'(an_n), 16'hB);
        chk("d2_pending_seg", 16'(seg_n), 16'h7F);
        goto(82);
        chk("hold_shown_an", 16'(an_n), 16'hE);
        chk("hold_shown_seg", 16'(seg_n), 16'h24);
        goto(87);
        chk("blank_an", 16'(an_n), 16'hD);
        chk("blank_seg", 16'(seg_n), 16'h7F);
        goto(92);
        chk("d2_last_an", 16'(an_n), 16'hB);
        chk("d2_last_seg", 16'(seg_n), 16'h4F);
        goto(95);
        chk("d2_last_seg_end", 16'(seg_n), 16'h4F);
        goto(100);
        chk("never_a", 16'(seen_a), 16'h0);

        // Mid-frame reset during digit 2 with a pending write
        goto(105);
        do_write(2'd3, 6'h07);
        goto(113);
        chk("pre_rst_an", 16'(an_n), 16'hB);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_an", 16'(an_n), 16'hF);
        chk("async_rst_seg", 16'(seg_n), 16'h7F);
        chk("async_rst_ready", 16'(load_ready), 16'h0);
        chk("async_rst_tick", 16'(frame_tick), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;

        step();
        chk("rerst_ready", 16'(load_ready), 16'h1);
        goto(2);
        chk("rerst_first_an", 16'(an_n), 16'hE);
        chk("rerst_first_seg", 16'(seg_n), 16'h7F);
        goto(5);
        do_write(2'd1, 6'h23);
        goto(20);
        chk("rerst_tick", 16'(frame_tick), 16'h1);
        goto(22);
        chk("rerst_d0_lost", 16'(seg_n), 16'h7F);
        goto(27);
        chk("blink_on_an", 16'(an_n), 16'hD);
        chk("blink_on_seg", 16'(seg_n), 16'h06);
        goto(37);
        chk("pending_lost_an", 16'(an_n), 16'h7);
        chk("pending_lost_seg", 16'(seg_n), 16'h7F);
`ifdef SEG_SCAN_BLINK_EN
        goto(47);
        chk("blink_off1", 16'(seg_n), 16'h7F);
        goto(67);
        chk("blink_off2", 16'(seg_n), 16'h7F);
`else
        goto(47);
        chk("blink_ignored1", 16'(seg_n), 16'h06);
        goto(67);
        chk("blink_ignored2", 16'(seg_n), 16'h06);
`endif
        goto(87);
        chk("blink_on_again", 16'(seg_n), 16'h06);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL have one clock `clk` and an asynchronous, active-high reset `rst`, and no other clock or reset.
REQ-002 Parameter SCAN_DIV SHALL default to 50000 and set the drive cycles per digit; legal range is 2..65535.
REQ-003 Parameter BLINK_DIV SHALL default to 64 and set the frames per blink half-period; legal range is 1..255.
REQ-004 The ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  async active-high reset
- load_valid  in  1  write request
- load_ready  out  1  write can be accepted
- load_idx  in  2  digit slot 0..3
- load_data  in  6  {blink, blank, value[3:0]}
- frame_tick  out  1  one-cycle pulse at frame wrap
- an_n  out  4  active-low digit enables, bit i = digit i
- seg_n  out  7  active-low segments, bit6=a .. bit0=g

Function
REQ-005 A write SHALL be accepted only in a cycle with load_valid=1 and load_ready=1, and SHALL go into shadow slot load_idx.
REQ-006 Shadow slots SHALL copy to the active slots only at frame wrap (digit 3 GAP ending), so a frame never shows mixed old and new data.
REQ-007 load_ready SHALL be 0 only in the commit cycle; a write presented then SHALL be held off and not lost.
REQ-008 The scan FSM SHALL have two states: DRIVE, lasting SCAN_DIV cycles, and GAP, lasting exactly 1 cycle.
REQ-009 FSM transitions SHALL be: DRIVE->GAP when the prescaler reaches SCAN_DIV-1; GAP->DRIVE with digit index incremented mod 4.
REQ-010 In GAP, an_n SHALL be 4'b1111 (anti-ghosting dead time).
REQ-011 In DRIVE, an_n SHALL hold 0 only at bit idx, and seg_n SHALL be the active-low hex pattern (0-F) of active value[idx].
REQ-012 seg_n and an_n SHALL be registered, changing 1 cycle after the FSM state or index changes.
REQ-013 A slot whose blank bit is 1 SHALL drive seg_n=7'h7F while its anode is still enabled.
REQ-014 frame_tick SHALL pulse in the same cycle as the commit.
REQ-015 A repeated write to the same slot within one frame SHALL leave the last accepted value in the shadow slot.

Reset
REQ-016 While rst=1, outputs SHALL be: an_n=4'hF, seg_n=7'h7F, load_ready=0, frame_tick=0.
REQ-017 While rst=1, internal state SHALL be: FSM=GAP, idx=3, prescaler=0, every shadow and active slot={0,1,0000} (blanked).
REQ-018 After rst deasserts, the first DRIVE SHALL show digit 0, and load_ready SHALL be 1 from the first clock edge.
REQ-019 Reset asserted mid-frame SHALL abort the scan immediately and discard any uncommitted shadow writes.

Configuration
REQ-020 With macro SEG_SCAN_BLINK_EN defined, a frame counter SHALL toggle a blink phase every BLINK_DIV frames, and slots with blink=1 SHALL be blanked during the off phase.
REQ-021 Without SEG_SCAN_BLINK_EN, the blink bit SHALL be stored but ignored, and the frame counter SHALL be omitted.

Structure
REQ-022 A shared package/include SHALL hold: the state encodings DRIVE/GAP, the load_data field offsets, and the all-off constants 4'hF and 7'h7F.
REQ-023 A single combinational sub-module seg_hex_decode (4-bit in, 7-bit active-low out) SHALL be instantiated once, on the muxed active value.

Verification (SCAN_DIV=4, BLINK_DIV=2)
REQ-024 Reset, then no writes -> an_n cycles 1110,1111,1101,1111,1011,1111,0111,1111 with each enable lasting 4 cycles; seg_n stays 7'h7F.
REQ-025 Write idx0={0,0,0x8} -> no change in the current frame; after frame_tick, digit 0 DRIVE shows seg_n=7'h00.
REQ-026 Hold load_valid in the commit cycle -> load_ready=0 that cycle; the write is accepted the next cycle and shows one frame later.
REQ-027 Write idx2=0xA then idx2=0x1 in the same frame -> digit 2 shows 7'h4F (1) and 0xA never appears.
REQ-028 With SEG_SCAN_BLINK_EN, write idx1={1,0,0x3} -> digit 1 shows 7'h06 for 2 frames and 7'h7F for 2 frames, repeating.
REQ-029 Assert rst during digit 2 DRIVE -> an_n=4'hF and seg_n=7'h7F asynchronously; pending writes are lost.
